// File: rtl/memwrite_pkg.sv
// rtl/memwrite_pkg.sv - shared types and defaults for the memwrite_check fill/hold/dump writer
package memwrite_pkg;

  typedef enum logic [1:0] {S_FILL, S_HOLD, S_DUMP} mw_state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;
  localparam DUMP_FILE = "memwrite_check.hex";

endpackage

// File: rtl/memwrite_ram.sv
// rtl/memwrite_ram.sv - DEPTH x DATA_W register array, one sync write port, one async read port
module memwrite_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents survive rst and are only ever overwritten by new fills.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memwrite_check.sv
// rtl/memwrite_check.sv - stores a valid/ready word stream, then scans it out as addr/data on request
module memwrite_check
  import memwrite_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  input  logic                     dump_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH)-1:0] out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   wr_count,
  output logic                     busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  mw_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   wr_count_q;
  logic [ADDR_W:0]   last_idx;
  logic              in_fire, out_fire;

  assign in_ready  = (state_q == S_FILL);
  assign out_valid = (state_q == S_DUMP);
  assign busy      = (state_q == S_DUMP);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_idx  = wr_count_q - (ADDR_W+1)'(1);
  assign out_last  = out_valid && ({1'b0, rd_ptr_q} == last_idx);
  assign out_addr  = rd_ptr_q;
  assign wr_count  = wr_count_q;

  memwrite_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (in_fire),
    .waddr(wr_ptr_q),
    .wdata(in_data),
    .raddr(rd_ptr_q),
    .rdata(out_data)
  );

  // A dump request wins over closing the burst; a write in the same cycle still lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (dump_req && (wr_count_q != '0))
          state_d = S_DUMP;
        else if (in_fire && (in_last || (wr_count_q == LAST_SLOT)))
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (dump_req) state_d = S_DUMP;
      end
      S_DUMP: begin
        if (out_fire && out_last) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        wr_count_q <= wr_count_q + 1'b1;
      end
      if (out_fire) begin
        if (out_last) begin
          wr_ptr_q   <= '0;
          wr_count_q <= '0;
          rd_ptr_q   <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memwrite_check.sv
// tb/tb_memwrite_check.sv - randomized scoreboard bench for memwrite_check
module tb_memwrite_check;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              dump_req = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [ADDR_W:0]   wr_count;
  logic              busy;

  memwrite_check #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last),
    .wr_count(wr_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int last;
  } item_t;

  item_t exp_q[$];
  int    mdl[$];      // words currently stored, in write order
  bit    exp_open;    // writer expected to accept words
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented scan-out word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got addr=%0d data=%0d expected no output", out_addr, out_data);
      end else begin
        chk("out_addr", int'(out_addr), exp_q[0].addr);
        chk("out_data", int'(out_data), exp_q[0].data);
        chk("out_last", int'(out_last), exp_q[0].last);
        chk("busy", int'(busy), 1);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_word(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = d[DATA_W-1:0];
    in_last  = last;
    chk("in_ready", int'(in_ready), int'(exp_open));
    if (exp_open) begin
      mdl.push_back(d & 8'hFF);
      if (last || mdl.size() == DEPTH) exp_open = 1'b0;
    end
    cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("wr_count", int'(wr_count), mdl.size());
  endtask

  task automatic queue_dump();
    for (int i = 0; i < mdl.size(); i++)
      exp_q.push_back('{addr: i, data: mdl[i], last: int'(i == mdl.size() - 1)});
    mdl.delete();
    exp_open = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for first 4 cycles
  task automatic run_dump(input int mode, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cycles >= 4);
      endcase
      cycle();
      cycles++;
    end
    out_ready = 1'b0;
    chk("dump_done", exp_q.size(), 0);
    exp_q.delete();
    exp_open = 1'b1;
    chk("post_wr_count", int'(wr_count), 0);
    chk("post_in_ready", int'(in_ready), 1);
    chk("post_out_valid", int'(out_valid), 0);
  endtask

  task automatic pulse_dump();
    dump_req = 1'b1;
    if (mdl.size() > 0) queue_dump();
    cycle();
    dump_req = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    exp_open = 1'b1;

    // reset
    cycle();
    cycle();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_wr_count", int'(wr_count), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    cycle();

    // short burst with in_last, full-rate drain
    drive_word(3, 1'b0);
    drive_word(5, 1'b0);
    drive_word(7, 1'b1);
    chk("hold_in_ready", int'(in_ready), 0);
    pulse_dump();
    run_dump(0, cyc);
    chk("burst3_cycles", cyc, 3);

    // fill to capacity, 17th word refused
    for (int i = 0; i < DEPTH; i++) drive_word(16 + i, 1'b0);
    drive_word(8'hAA, 1'b0);
    chk("full_wr_count", int'(wr_count), DEPTH);
    pulse_dump();
    run_dump(0, cyc);
    chk("full_cycles", cyc, DEPTH);

    // backpressure on a 2-word dump (burst left open)
    drive_word(8'h5A, 1'b0);
    drive_word(8'hC3, 1'b0);
    pulse_dump();
    run_dump(2, cyc);
    chk("bp_cycles", cyc, 6);

    // dump request with nothing stored is ignored
    pulse_dump();
    chk("empty_out_valid", int'(out_valid), 0);
    chk("empty_in_ready", int'(in_ready), 1);
    cycle();
    chk("empty_busy", int'(busy), 0);

    // dump request in the same cycle as the second write
    drive_word(8'h11, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    dump_req = 1'b1;
    chk("same_cyc_in_ready", int'(in_ready), 1);
    mdl.push_back(8'h22);
    queue_dump();
    cycle();
    in_valid = 1'b0;
    dump_req = 1'b0;
    run_dump(0, cyc);
    chk("same_cyc_cycles", cyc, 2);

    // reset in the middle of a dump, after addr 1 is accepted
    for (int i = 0; i < 5; i++) drive_word($urandom_range(0, 255), i == 4);
    pulse_dump();
    n = exp_q.size();
    cyc = 0;
    out_ready = 1'b1;
    while (exp_q.size() > n - 2 && cyc < 50) begin
      cycle();
      cyc++;
    end
    chk("mid_dump_reached", exp_q.size(), n - 2);
    rst = 1'b1;
    out_ready = 1'b0;
    cycle();
    exp_q.delete();
    mdl.delete();
    exp_open = 1'b1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_wr_count", int'(wr_count), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    cycle();

    // randomized bursts with random backpressure
    for (int r = 0; r < 8; r++) begin
      int len;
      bit use_last;
      len = $urandom_range(1, DEPTH);
      use_last = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++)
        drive_word($urandom_range(0, 255), use_last && (i == len - 1));
      if (!exp_open) drive_word($urandom_range(0, 255), 1'b0);
      pulse_dump();
      run_dump(1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
